// File: rtl/ssram_master.sv
`default_nettype none
// ============================================================================
// Module     : ssram_master
// Description: Bus initiator for the hwag SSRAM-style register port.
//              Converts host commands into single/burst write or read cycles,
//              owns the shared data bus only while writing, inserts idle
//              turnaround clocks after every command and streams read data
//              back to the host.
// Ports      : clk, rst (async, active-low)
//              cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : command channel
//              wdata_valid/wdata_ready/wdata                  : write beat stream
//              rdata_valid/rdata/rdata_last                   : read beat stream
//              busy                                           : command in flight
//              ssram_we/ssram_re/ssram_addr/ssram_data        : SSRAM port
// Revision   : 1.0 - initial release
// ============================================================================
module ssram_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 6,
  parameter int RD_LATENCY = 1,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  busy,
  output logic                  ssram_we,
  output logic                  ssram_re,
  output logic [ADDR_WIDTH-1:0] ssram_addr,
  inout  wire  [DATA_WIDTH-1:0] ssram_data
);

  localparam int CNT_W  = LEN_WIDTH + 1;
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    TURN  = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;          // next address to use
  logic [CNT_W-1:0]      beats, beats_n;        // write beats / read addresses still to go
  logic [CNT_W-1:0]      rcv, rcv_n;            // read beats still to be sampled
  logic [TURN_W-1:0]     turn_cnt, turn_n;
  logic [RD_LATENCY-1:0] pipe, pipe_n;          // tracks issued read addresses until data is due
  logic [DATA_WIDTH-1:0] data_out, data_out_n;
  logic                  drive, drive_n;
  logic                  cmd_ready_n, wdata_ready_n, busy_n;
  logic                  we_n, re_n, rvalid_n, rlast_n;
  logic [ADDR_WIDTH-1:0] ssram_addr_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic                  sample, last_sample;

  assign ssram_data = drive ? data_out : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_n       = state;
    addr_n        = addr;
    beats_n       = beats;
    rcv_n         = rcv;
    turn_n        = turn_cnt;
    data_out_n    = data_out;
    drive_n       = drive;
    cmd_ready_n   = cmd_ready;
    wdata_ready_n = wdata_ready;
    busy_n        = busy;
    we_n          = 1'b0;
    re_n          = 1'b0;
    ssram_addr_n  = ssram_addr;
    rdata_n       = rdata;
    rvalid_n      = 1'b0;
    rlast_n       = 1'b0;

    // The registered re of the previous clock enters the pipe; its tail marks
    // the edge at which that address's data is on the bus.
    pipe_n      = RD_LATENCY'({pipe, ssram_re});
    sample      = pipe[RD_LATENCY-1];
    last_sample = sample && (rcv == CNT_W'(1));

    if (sample) begin
      rdata_n  = ssram_data;
      rvalid_n = 1'b1;
      rlast_n  = last_sample;
      rcv_n    = rcv - CNT_W'(1);
    end

    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        busy_n      = 1'b0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          busy_n      = 1'b1;
          if (cmd_write) begin
            state_n       = WRITE;
            addr_n        = cmd_addr;
            beats_n       = {1'b0, cmd_len} + CNT_W'(1);
            wdata_ready_n = 1'b1;
            drive_n       = 1'b1;
          end else begin
            // First read address goes out on the accepting edge.
            state_n      = READ;
            re_n         = 1'b1;
            ssram_addr_n = cmd_addr;
            addr_n       = cmd_addr + ADDR_WIDTH'(1);
            beats_n      = {1'b0, cmd_len};
            rcv_n        = {1'b0, cmd_len} + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        if (beats == '0) begin
          // The final beat's strobe clock has completed; release the bus.
          state_n = TURN;
          drive_n = 1'b0;
          turn_n  = TURN_W'(TURNAROUND - 1);
        end else if (wdata_valid && wdata_ready) begin
          we_n          = 1'b1;
          ssram_addr_n  = addr;
          data_out_n    = wdata;
          addr_n        = addr + ADDR_WIDTH'(1);
          beats_n       = beats - CNT_W'(1);
          wdata_ready_n = (beats != CNT_W'(1));
        end
      end
      READ: begin
        if (beats == '0) begin
          state_n = DRAIN;
        end else begin
          re_n         = 1'b1;
          ssram_addr_n = addr;
          addr_n       = addr + ADDR_WIDTH'(1);
          beats_n      = beats - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (last_sample) begin
          state_n = TURN;
          turn_n  = TURN_W'(TURNAROUND - 1);
        end
      end
      TURN: begin
        if (turn_cnt == '0) begin
          state_n     = IDLE;
          busy_n      = 1'b0;
          cmd_ready_n = 1'b1;
        end else begin
          turn_n = turn_cnt - TURN_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        drive_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      beats       <= '0;
      rcv         <= '0;
      turn_cnt    <= '0;
      pipe        <= '0;
      data_out    <= '0;
      drive       <= 1'b0;
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      busy        <= 1'b0;
      ssram_we    <= 1'b0;
      ssram_re    <= 1'b0;
      ssram_addr  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      beats       <= beats_n;
      rcv         <= rcv_n;
      turn_cnt    <= turn_n;
      pipe        <= pipe_n;
      data_out    <= data_out_n;
      drive       <= drive_n;
      cmd_ready   <= cmd_ready_n;
      wdata_ready <= wdata_ready_n;
      busy        <= busy_n;
      ssram_we    <= we_n;
      ssram_re    <= re_n;
      ssram_addr  <= ssram_addr_n;
      rdata       <= rdata_n;
      rdata_valid <= rvalid_n;
      rdata_last  <= rlast_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssram_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_ssram_master
// Description: Directed and randomized bench for ssram_master with an SSRAM
//              slave model and an array-based reference of memory contents.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ssram_master;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LW  = 6;
  localparam int RDL = 1;
  localparam int TA  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          cmd_ready, wdata_ready, rdata_valid, rdata_last, busy, ssram_we, ssram_re;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ssram_addr;
  wire  [DW-1:0] ssram_data;

  ssram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                 .RD_LATENCY(RDL), .TURNAROUND(TA)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .busy(busy), .ssram_we(ssram_we), .ssram_re(ssram_re),
    .ssram_addr(ssram_addr), .ssram_data(ssram_data)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 40503 + 77);
  endfunction

  // ---------------- SSRAM slave (hwag register file) ----------------
  logic          preload = 1'b0;
  logic [DW-1:0] mem [256];
  logic [RDL-1:0] sv;
  logic [AW-1:0] sa [RDL];
  logic          slv_drv;

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (ssram_we) mem[ssram_addr] <= ssram_data;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) sv <= '0;
    else begin
      sv[0] <= ssram_re;
      sa[0] <= ssram_addr;
      for (int i = 1; i < RDL; i++) begin
        sv[i] <= sv[i-1];
        sa[i] <= sa[i-1];
      end
    end
  end

  assign slv_drv    = sv[RDL-1];
  assign ssram_data = slv_drv ? mem[sa[RDL-1]] : {DW{1'bz}};

  // ---------------- bus monitor ----------------
  int            cyc = 0;
  logic [AW-1:0] wq_a[$];
  logic [DW-1:0] wq_d[$];
  int            wq_c[$];
  logic [AW-1:0] ra_a[$];
  int            ra_c[$];
  logic [DW-1:0] rd_d[$];
  logic          rd_l[$];
  int            rd_c[$];
  int            zviol = 0, holdviol = 0, bothviol = 0, gapviol = 0;
  logic [DW-1:0] last_wd = '0;
  logic          had_w = 1'b0, any_dir = 1'b0, last_dir_w = 1'b0;
  int            dead = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (ssram_we && ssram_re) bothviol++;
      if (ssram_we) begin
        wq_a.push_back(ssram_addr); wq_d.push_back(ssram_data); wq_c.push_back(cyc);
        last_wd = ssram_data; had_w = 1'b1;
      end else if (wdata_ready && had_w && ssram_data !== last_wd) holdviol++;
      if (!busy) had_w = 1'b0;
      if (!slv_drv && !ssram_we && !wdata_ready && ssram_data !== {DW{1'bz}}) zviol++;
      if ((ssram_we || wdata_ready) && $isunknown(ssram_data)) zviol++;
      if (ssram_we || ssram_re) begin
        if (any_dir && (last_dir_w != ssram_we) && dead < TA) gapviol++;
        any_dir = 1'b1; last_dir_w = ssram_we; dead = 0;
      end else dead++;
      if (ssram_re) begin ra_a.push_back(ssram_addr); ra_c.push_back(cyc); end
      if (rdata_valid) begin rd_d.push_back(rdata); rd_l.push_back(rdata_last); rd_c.push_back(cyc); end
    end else begin
      had_w = 1'b0; any_dir = 1'b0; dead = 0;
    end
  end

  // ---------------- checking helpers ----------------
  int            errors = 0, checks = 0;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wbuf [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int g = 0;
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    ok = cmd_ready;
  endtask

  task automatic clear_q();
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    ra_a.delete(); ra_c.delete();
    rd_d.delete(); rd_l.delete(); rd_c.delete();
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                            input int stall_at, input int stall_n, input string tag);
    int beat = 0, st = 0, g = 0, n = 0, bad = 0;
    bit ok, tk;
    wait_ready(ok);
    chk({tag, " cmd_ready"}, 32'(ok), 32'd1);
    clear_q();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom); cmd_write = 1'b0;
    while (beat <= int'(l) && g < 2000) begin
      if (beat == stall_at && st < stall_n) begin
        wdata_valid = 1'b0; wdata = DW'($urandom); st++;
      end else begin
        wdata_valid = 1'b1; wdata = wbuf[beat];
      end
      tk = wdata_valid && wdata_ready;
      @(negedge clk); g++;
      if (tk) beat++;
    end
    wdata_valid = 1'b0;
    chk({tag, " write beats accepted"}, 32'(beat), 32'(int'(l) + 1));
    for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % 256] = wbuf[i];
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, " clocks from last strobe to idle"}, 32'(n), 32'(TA + 1));
    chk({tag, " busy at idle"}, 32'(busy), 32'd0);
    chk({tag, " strobe count"}, 32'(wq_a.size()), 32'(int'(l) + 1));
    for (int i = 0; i < wq_a.size() && i <= int'(l); i++) begin
      if (wq_a[i] !== AW'((int'(a) + i) % 256)) bad++;
      if (wq_d[i] !== wbuf[i]) bad++;
    end
    chk({tag, " strobe addr/data errors"}, 32'(bad), 32'd0);
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input string tag);
    int n = 0, bad = 0, badd = 0;
    bit ok;
    wait_ready(ok);
    chk({tag, " cmd_ready"}, 32'(ok), 32'd1);
    clear_q();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom); cmd_write = 1'b1;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    chk({tag, " read completes"}, 32'(cmd_ready), 32'd1);
    chk({tag, " address count"}, 32'(ra_a.size()), 32'(int'(l) + 1));
    for (int i = 0; i < ra_a.size(); i++) begin
      if (ra_a[i] !== AW'((int'(a) + i) % 256)) bad++;
      if (ra_c[i] != ra_c[0] + i) bad++;
    end
    chk({tag, " address sequence errors"}, 32'(bad), 32'd0);
    chk({tag, " beat count"}, 32'(rd_d.size()), 32'(int'(l) + 1));
    for (int i = 0; i < rd_d.size(); i++) begin
      if (rd_d[i] !== ref_mem[(int'(a) + i) % 256]) badd++;
      if (rd_l[i] !== (i == int'(l))) badd++;
      if (i < ra_c.size() && rd_c[i] != ra_c[i] + RDL + 1) badd++;
    end
    chk({tag, " beat data/last/timing errors"}, 32'(badd), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, bad;
    logic [AW-1:0] exp_wrap [4];
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;

    // Reset values and release
    chk("rst cmd_ready", 32'(cmd_ready), 0);
    chk("rst wdata_ready", 32'(wdata_ready), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst we/re", {30'd0, ssram_we, ssram_re}, 0);
    chk("rst addr", 32'(ssram_addr), 0);
    chk("rst rdata/valid/last", {rdata_valid, rdata_last, 14'd0, rdata}, 0);
    chk("rst bus z", 32'(ssram_data === {DW{1'bz}}), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("cmd_ready one edge after release", 32'(cmd_ready), 1);

    // Single write then readback
    wbuf[0] = 16'h1234;
    host_write(8'h05, 6'd0, -1, 0, "single wr");
    if (wq_a.size() > 0) begin
      chk("single wr addr", 32'(wq_a[0]), 32'h05);
      chk("single wr data", 32'(wq_d[0]), 32'h1234);
    end
    chk("hwag reg5", 32'(mem[5]), 32'h1234);
    host_read(8'h05, 6'd0, "single rd");

    // Full-length burst write and read
    for (int i = 0; i < 64; i++) wbuf[i] = DW'(2 * i);
    host_write(8'h00, 6'd63, -1, 0, "burst wr");
    if (wq_c.size() == 64) chk("burst wr back-to-back span", 32'(wq_c[63] - wq_c[0]), 32'd63);
    host_read(8'h00, 6'd63, "burst rd");
    if (rd_d.size() == 64) chk("burst rd beat64", {15'd0, rd_l[63], rd_d[63]}, {15'd0, 1'b1, 16'd126});

    // Address wrap
    host_read(8'hFE, 6'd3, "wrap rd");
    exp_wrap[0] = 8'hFE; exp_wrap[1] = 8'hFF; exp_wrap[2] = 8'h00; exp_wrap[3] = 8'h01;
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= ra_a.size() || ra_a[i] !== exp_wrap[i]) bad++;
    chk("wrap addresses FE FF 00 01", 32'(bad), 0);

    // Write stall of 3 clocks between beats
    for (int i = 0; i < 64; i++) wbuf[i] = DW'($urandom);
    host_write(8'h40, 6'd4, 1, 3, "stall wr");
    if (wq_c.size() >= 3) begin
      chk("stall gap", 32'(wq_c[1] - wq_c[0]), 32'd4);
      chk("post-stall gap", 32'(wq_c[2] - wq_c[1]), 32'd1);
    end
    host_read(8'h40, 6'd4, "stall rd");

    // Randomized traffic
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      a = AW'($urandom);
      l = LW'($urandom_range(0, 24));
      for (int i = 0; i < 64; i++) wbuf[i] = DW'($urandom);
      host_write(a, l, int'($urandom_range(0, 24)), int'($urandom_range(0, 3)), $sformatf("rand wr%0d", r));
      host_read(AW'(int'(a) + int'($urandom_range(0, 8)) - 4), LW'($urandom_range(0, 40)), $sformatf("rand rd%0d", r));
    end

    // Reset in the middle of a 32-beat read
    begin
      bit ok;
      wait_ready(ok);
      clear_q();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 6'd31;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (rd_d.size() < 10 && n < 200) begin @(negedge clk); n++; end
      chk("mid-read reached beat 10", 32'(rd_d.size() >= 10), 1);
      #1 rst = 1'b0;
      #1;
      chk("mid rst re", 32'(ssram_re), 0);
      chk("mid rst rdata_valid/last", {30'd0, rdata_valid, rdata_last}, 0);
      chk("mid rst busy/cmd_ready", {30'd0, busy, cmd_ready}, 0);
      chk("mid rst addr/rdata", {8'd0, ssram_addr, rdata}, 0);
      chk("mid rst bus z", 32'(ssram_data === {DW{1'bz}}), 1);
      bad = 0;
      for (int i = 0; i < rd_d.size(); i++) begin
        if (rd_l[i] !== 1'b0) bad++;
        if (rd_d[i] !== ref_mem[(16 + i) % 256]) bad++;
      end
      chk("aborted read beats", 32'(bad), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("cmd_ready after mid rst", 32'(cmd_ready), 1);
    end
    for (int i = 0; i < 64; i++) wbuf[i] = DW'($urandom);
    host_write(8'h20, 6'd7, -1, 0, "post rst wr");
    host_read(8'h1C, 6'd15, "post rst rd");

    // Whole-run bus rules and final memory image
    chk("bus Z/drive violations", 32'(zviol), 0);
    chk("stall hold violations", 32'(holdviol), 0);
    chk("we&re overlap", 32'(bothviol), 0);
    chk("turnaround gap violations", 32'(gapviol), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("memory image mismatches", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
